// File: rtl/jstk_spi_poller.sv
// jstk_spi_poller: periodic 5-byte SPI mode-0 poll of a PmodJSTK, publishing X/Y/buttons atomically.
module jstk_spi_poller #(
  parameter int unsigned SCLK_HALF = 50,
  parameter int unsigned SS_SETUP  = 1500,
  parameter int unsigned BYTE_GAP  = 1000,
  parameter int unsigned POLL_GAP  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  led_cmd,
  input  logic        miso,
  output logic        ss_n,
  output logic        sclk,
  output logic        mosi,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [2:0]  buttons,
  output logic        sample_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;
  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx, byte_idx;
  logic [6:0]  tx;
  logic [7:0]  rx_sr;
  logic [9:0]  xs, ys;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      tx           <= '0;
      rx_sr        <= '0;
      xs           <= '0;
      ys           <= '0;
      ss_n         <= 1'b1;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      x            <= 11'd512;
      y            <= 11'd512;
      buttons      <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cnt == POLL_GAP - 1) begin
            state    <= SETUP;
            cnt      <= '0;
            ss_n     <= 1'b0;
            busy     <= 1'b1;
            mosi     <= 1'b1;
            tx       <= {5'b0, led_cmd};
            bit_idx  <= '0;
            byte_idx <= '0;
          end else cnt <= cnt + 1;
        end
        SETUP: begin
          state <= (cnt == SS_SETUP - 1) ? SHIFT : SETUP;
          cnt   <= (cnt == SS_SETUP - 1) ? '0 : cnt + 1;
        end
        SHIFT: begin
          cnt <= (cnt == 2 * SCLK_HALF - 1) ? '0 : cnt + 1;
          if (cnt == SCLK_HALF - 1) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end
          if (cnt == 2 * SCLK_HALF - 1) begin
            sclk    <= 1'b0;
            mosi    <= tx[6];
            tx      <= {tx[5:0], 1'b0};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              case (byte_idx)
                3'd0:    xs[7:0] <= rx_sr;
                3'd1:    xs[9:8] <= rx_sr[1:0];
                3'd2:    ys[7:0] <= rx_sr;
                3'd3:    ys[9:8] <= rx_sr[1:0];
                default: ;
              endcase
              if (byte_idx == 3'd4) begin
                // last byte goes straight to buttons so all outputs update in the same edge
                state        <= DONE;
                ss_n         <= 1'b1;
                sample_valid <= 1'b1;
                x            <= {1'b0, xs};
                y            <= {1'b0, ys};
                buttons      <= rx_sr[2:0];
              end else begin
                state    <= GAP;
                byte_idx <= byte_idx + 3'd1;
                mosi     <= 1'b0;
                tx       <= '0;
              end
            end
          end
        end
        GAP: begin
          state <= (cnt == BYTE_GAP - 1) ? SHIFT : GAP;
          cnt   <= (cnt == BYTE_GAP - 1) ? '0 : cnt + 1;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jstk_spi_poller.sv
// tb_jstk_spi_poller: directed and random PmodJSTK transactions against a byte-level slave/reference model.
module tb_jstk_spi_poller;
  localparam int H = 2, SU = 4, BG = 3, PG = 10;
  localparam int LOW = SU + 80 * H + 4 * BG;
  logic clk = 0, rst = 1, miso = 0;
  logic [1:0] led_cmd = 0;
  logic ss_n, sclk, mosi, sample_valid, busy;
  logic [10:0] x, y;
  logic [2:0] buttons;
  int tests = 0, fails = 0;
  logic [39:0] data;
  logic [1:0] led;
  int rises, guard;
  always #5 clk = ~clk;
  jstk_spi_poller #(.SCLK_HALF(H), .SS_SETUP(SU), .BYTE_GAP(BG), .POLL_GAP(PG)) dut (
    .clk(clk), .rst(rst), .led_cmd(led_cmd), .miso(miso), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .x(x), .y(y), .buttons(buttons), .sample_valid(sample_valid), .busy(busy));
  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] axis(input logic [7:0] lo, input logic [7:0] hi);
    return 11'(int'(lo) + 256 * (int'(hi) % 4));
  endfunction
  task automatic txn(input logic [39:0] d, input logic [1:0] led_mid, input int mid_rise, input logic [7:0] exp_b0);
    int idle = 0, low = 0, nr = 0, hi_run = 0, sv = 0;
    bit bad_mosi = 0, bad_hi = 0, bad_busy = 0, prev_sclk = 0;
    logic prev_mosi;
    logic [39:0] cap = '0;
    do begin
      @(negedge clk);
      idle++;
      if (sample_valid) sv++;
    end while (ss_n && idle < 100);
    check("start_delay", 40'(idle), 40'(PG));
    miso = d[39];
    prev_mosi = mosi;
    while (!ss_n && low < 1000) begin
      low++;
      if (!busy) bad_busy = 1;
      if (sample_valid) sv++;
      if (sclk) hi_run++;
      if (sclk && !prev_sclk) begin
        cap = {cap[38:0], mosi};
        if (mosi !== prev_mosi) bad_mosi = 1;
        nr++;
        if (nr < 40) miso = d[39 - nr];
        if (nr == mid_rise) led_cmd = led_mid;
      end
      if (!sclk && prev_sclk) begin
        if (hi_run != H) bad_hi = 1;
        hi_run = 0;
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      @(negedge clk);
    end
    if (prev_sclk && hi_run != H) bad_hi = 1;
    check("ss_low_cycles", 40'(low), 40'(LOW));
    check("sclk_rises", 40'(nr), 40'd40);
    check("mosi_byte0", 40'(cap[39:32]), 40'(exp_b0));
    check("mosi_bytes1to4", 40'(cap[31:0]), 40'd0);
    check("mosi_stable", 40'(bad_mosi), 40'd0);
    check("sclk_high_width", 40'(bad_hi), 40'd0);
    check("busy_window", 40'(bad_busy), 40'd0);
    check("no_early_valid", 40'(sv), 40'd0);
    check("valid_pulse", 40'(sample_valid), 40'd1);
    check("busy_in_done", 40'(busy), 40'd1);
    check("sclk_done", 40'(sclk), 40'd0);
    check("x", 40'(x), 40'(axis(d[39:32], d[31:24])));
    check("y", 40'(y), 40'(axis(d[23:16], d[15:8])));
    check("buttons", 40'(buttons), 40'(int'(d[7:0]) % 8));
    @(negedge clk);
    check("valid_one_cycle", 40'(sample_valid), 40'd0);
    check("busy_after", 40'(busy), 40'd0);
    check("x_hold", 40'(x), 40'(axis(d[39:32], d[31:24])));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss_n", 40'(ss_n), 40'd1);
    check("rst_sclk", 40'(sclk), 40'd0);
    check("rst_mosi", 40'(mosi), 40'd0);
    check("rst_x", 40'(x), 40'd512);
    check("rst_y", 40'(y), 40'd512);
    check("rst_buttons", 40'(buttons), 40'd0);
    check("rst_valid", 40'(sample_valid), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    led_cmd = 2'b10;
    rst = 0;
    txn(40'hA5_03_3C_01_05, 2'b01, 4, 8'h82);
    txn(40'hFF_FE_00_FC_F8, 2'b01, -1, 8'h81);
    for (int i = 0; i < 4; i++) begin
      led = 2'($urandom);
      led_cmd = led;
      data = {32'($urandom), 8'($urandom)};
      txn(data, 2'($urandom), int'($urandom_range(1, 40)), 8'h80 | 8'(led));
      led_cmd = led;
    end
    led_cmd = 2'b11;
    guard = 0;
    while (ss_n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rst_test_start", 40'(ss_n), 40'd0);
    rises = 0;
    guard = 0;
    while (rises < 20 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (sclk) begin
        rises++;
        while (sclk && guard < 500) begin
          @(negedge clk);
          guard++;
        end
      end
    end
    check("reach_byte2", 40'(rises), 40'd20);
    rst = 1;
    @(negedge clk);
    check("midrst_ss_n", 40'(ss_n), 40'd1);
    check("midrst_sclk", 40'(sclk), 40'd0);
    check("midrst_x", 40'(x), 40'd512);
    check("midrst_y", 40'(y), 40'd512);
    check("midrst_buttons", 40'(buttons), 40'd0);
    check("midrst_valid", 40'(sample_valid), 40'd0);
    check("midrst_busy", 40'(busy), 40'd0);
    rst = 0;
    data = {32'($urandom), 8'($urandom)};
    txn(data, 2'b11, -1, 8'h83);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
